// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter; one outstanding transaction at a time.
// Optional round-robin arbitration is enabled by defining MEM_ARBITER_RR_EN (default: fixed LSU priority).
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic [1:0] {G_NONE, G_IFU, G_LSU} grant_t;

    state_t            state;
    grant_t            grant;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;

    logic pick_lsu;
    logic accept_ifu;
    logic accept_lsu;
    logic ifu_owns_resp;
    logic lsu_owns_resp;

`ifdef MEM_ARBITER_RR_EN
    logic last_lsu;

    // On contention the master that did not win last time goes first.
    always_comb pick_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu);

    always_ff @(posedge clk) begin
        if (rst)
            last_lsu <= 1'b0;
        else if (accept_lsu)
            last_lsu <= 1'b1;
        else if (accept_ifu)
            last_lsu <= 1'b0;
    end
`else
    always_comb pick_lsu = lsu_req_valid;
`endif

    // A request arriving during reset is never accepted, so ready is held low too.
    assign accept_lsu = (state == IDLE) && !rst && pick_lsu;
    assign accept_ifu = (state == IDLE) && !rst && ifu_req_valid && !pick_lsu;

    assign ifu_req_ready = accept_ifu;
    assign lsu_req_ready = accept_lsu;

    assign ifu_owns_resp = (state == RESP) && (grant == G_IFU);
    assign lsu_owns_resp = (state == RESP) && (grant == G_LSU);

    assign ifu_resp_valid = ifu_owns_resp && mem_resp_valid;
    assign lsu_resp_valid = lsu_owns_resp && mem_resp_valid;
    assign ifu_rdata      = ifu_owns_resp ? mem_rdata : '0;
    assign lsu_rdata      = lsu_owns_resp ? mem_rdata : '0;
    assign mem_resp_ready = (ifu_owns_resp && ifu_resp_ready) ||
                            (lsu_owns_resp && lsu_resp_ready);

    assign mem_req_valid = (state == REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    // NOTE: all state here is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= G_NONE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_lsu) begin
                        grant   <= G_LSU;
                        addr_q  <= lsu_addr;
                        wen_q   <= lsu_wen;
                        wdata_q <= lsu_wdata;
                        wmask_q <= lsu_wmask;
                        state   <= REQ;
                    end else if (accept_ifu) begin
                        grant   <= G_IFU;
                        addr_q  <= ifu_addr;
                        wen_q   <= 1'b0;
                        wdata_q <= '0;
                        wmask_q <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready)
                        state <= RESP;
                end
                RESP: begin
                    if (mem_resp_valid && mem_resp_ready) begin
                        grant <= G_NONE;
                        state <= IDLE;
                    end
                end
                default: begin
                    grant <= G_NONE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: inputs change 1ns after posedge,
// outputs are compared 1ns later, well clear of the next active edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Drives the REQ and RESP phases of a granted transaction and checks both.
    task automatic serve(input bit is_lsu, input logic [31:0] addr, input logic [31:0] rdata);
        check("serve_req_valid", mem_req_valid, 1'b1);
        check("serve_addr", mem_addr, addr);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = rdata;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        settle();
        check("serve_ifu_resp_valid", ifu_resp_valid, !is_lsu);
        check("serve_lsu_resp_valid", lsu_resp_valid, is_lsu);
        check("serve_rdata", is_lsu ? lsu_rdata : ifu_rdata, rdata);
        check("serve_other_rdata", is_lsu ? ifu_rdata : lsu_rdata, 32'h0);
        step();
        mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0;
        lsu_resp_ready = 1'b0;
        settle();
    endtask

    initial begin
        rst = 1'b1;
        {ifu_req_valid, ifu_resp_ready, lsu_req_valid, lsu_wen, lsu_resp_ready} = '0;
        {mem_req_ready, mem_resp_valid} = '0;
        ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; mem_rdata = '0;
        step();
        step();

        // Reset: everything low, even with a pending IFU request.
        ifu_req_valid = 1'b1;
        settle();
        check("rst_ifu_req_ready", ifu_req_ready, 1'b0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_resp_ready", mem_resp_ready, 1'b0);
        ifu_req_valid = 1'b0;
        step();
        rst = 1'b0;

        // IFU only: accept in cycle 0, mem request in cycle 1, response in cycle 2.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        settle();
        check("ifu_c0_req_ready", ifu_req_ready, 1'b1);
        check("ifu_c0_lsu_ready", lsu_req_ready, 1'b0);
        check("ifu_c0_mem_valid", mem_req_valid, 1'b0);
        step();
        ifu_req_valid = 1'b0;
        ifu_addr      = 32'h0;
        settle();
        check("ifu_c1_mem_wen", mem_wen, 1'b0);
        check("ifu_c1_mem_wmask", mem_wmask, 8'h00);
        check("ifu_c1_resp_ready", mem_resp_ready, 1'b0);
        serve(1'b0, 32'h8000_0000, 32'h0000_0413);
        check("ifu_idle_mem_valid", mem_req_valid, 1'b0);

        // Simultaneous IFU fetch and LSU load: LSU first, IFU accepted in the bubble.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b0;
        settle();
        check("pair1_lsu_ready", lsu_req_ready, 1'b1);
        check("pair1_ifu_ready", ifu_req_ready, 1'b0);
        step();
        lsu_req_valid = 1'b0;
        settle();
        check("pair1_ifu_wait_req", ifu_req_ready, 1'b0);
        serve(1'b1, 32'h8000_1000, 32'h1111_1111);
        check("pair1_ifu_bubble_ready", ifu_req_ready, 1'b1);
        step();
        ifu_req_valid = 1'b0;
        settle();
        serve(1'b0, 32'h8000_0004, 32'h2222_2222);

        // LSU store with request stall; mem_resp_valid noise is ignored in REQ.
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
        settle();
        check("st_lsu_ready", lsu_req_ready, 1'b1);
        step();
        lsu_req_valid = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 8'h00; lsu_wen = 1'b0;
        mem_resp_valid = 1'b1; lsu_resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("st_stall_valid", mem_req_valid, 1'b1);
            check("st_stall_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("st_stall_wmask", mem_wmask, 8'h0F);
            check("st_stall_wen", mem_wen, 1'b1);
            check("st_stall_addr", mem_addr, 32'h8000_2000);
            check("st_stall_resp_ready", mem_resp_ready, 1'b0);
            check("st_stall_lsu_resp", lsu_resp_valid, 1'b0);
            step();
        end
        mem_resp_valid = 1'b0; lsu_resp_ready = 1'b0;
        mem_req_ready  = 1'b1;
        step();
        mem_req_ready  = 1'b0;

        // Response backpressure: LSU not ready for two cycles.
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0ACC;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("bp_mem_resp_ready", mem_resp_ready, 1'b0);
            check("bp_lsu_resp_valid", lsu_resp_valid, 1'b1);
            check("bp_ifu_resp_valid", ifu_resp_valid, 1'b0);
            check("bp_mem_req_valid", mem_req_valid, 1'b0);
            step();
        end
        lsu_resp_ready = 1'b1;
        settle();
        check("bp_done_resp_ready", mem_resp_ready, 1'b1);
        check("bp_done_ifu_resp", ifu_resp_valid, 1'b0);
        step();
        lsu_resp_ready = 1'b0;
        settle();
        check("bp_idle_lsu_resp", lsu_resp_valid, 1'b0);
        mem_resp_valid = 1'b0;

        // Second simultaneous pair, right after an LSU grant.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000;
        settle();
`ifdef MEM_ARBITER_RR_EN
        check("pair2_ifu_ready", ifu_req_ready, 1'b1);
        check("pair2_lsu_ready", lsu_req_ready, 1'b0);
        step();
        ifu_req_valid = 1'b0;
        settle();
        serve(1'b0, 32'h8000_0010, 32'h3333_3333);
        check("pair2_lsu_bubble_ready", lsu_req_ready, 1'b1);
        step();
        lsu_req_valid = 1'b0;
        settle();
        serve(1'b1, 32'h8000_3000, 32'h4444_4444);
`else
        check("pair2_ifu_ready", ifu_req_ready, 1'b0);
        check("pair2_lsu_ready", lsu_req_ready, 1'b1);
        step();
        lsu_req_valid = 1'b0;
        settle();
        serve(1'b1, 32'h8000_3000, 32'h4444_4444);
        check("pair2_ifu_bubble_ready", ifu_req_ready, 1'b1);
        step();
        ifu_req_valid = 1'b0;
        settle();
        serve(1'b0, 32'h8000_0010, 32'h3333_3333);
`endif

        // Reset while in RESP: transaction dropped, then a fresh fetch works.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0020;
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h5555_5555;
        settle();
        check("rr_pre_ifu_resp_valid", ifu_resp_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check("rr_ifu_resp_valid", ifu_resp_valid, 1'b0);
        check("rr_ifu_rdata", ifu_rdata, 32'h0);
        check("rr_mem_resp_ready", mem_resp_ready, 1'b0);
        check("rr_mem_req_valid", mem_req_valid, 1'b0);
        check("rr_mem_addr", mem_addr, 32'h0);
        mem_resp_valid = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
        settle();
        check("rr_fresh_ready", ifu_req_ready, 1'b1);
        step();
        ifu_req_valid = 1'b0;
        settle();
        serve(1'b0, 32'h8000_0008, 32'h0000_0013);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter that shares the single data memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between IFU/LSU and the memory model, on the same valid/ready handshake the pipeline stages use.
- Serialises transactions: exactly one outstanding request at a time; the grant is held until the response handshake completes.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MASK_W, 8, write byte-mask width (matches LSU mask)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_req_valid  in  1  IFU request valid
- ifu_req_ready  out  1  IFU request accepted
- ifu_addr  in  ADDR_W  IFU fetch address
- ifu_resp_valid  out  1  IFU read data valid
- ifu_resp_ready  in  1  IFU can take response
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request valid
- lsu_req_ready  out  1  LSU request accepted
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  LSU write enable
- lsu_wdata  in  DATA_W  LSU write data
- lsu_wmask  in  MASK_W  LSU byte mask
- lsu_resp_valid  out  1  LSU response valid
- lsu_resp_ready  in  1  LSU can take response
- lsu_rdata  out  DATA_W  LSU read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/MASK_W  latched request fields
- mem_resp_valid  in  1  memory response valid
- mem_resp_ready  out  1  arbiter takes response
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. Sampled only on posedge clk.
- Reset values:
  - state = IDLE, grant = NONE, last_grant = IFU
  - latched addr/wen/wdata/wmask = 0
  - All outputs 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Arbitration picks a winner among asserted req_valids.
  - The winner's req_ready = 1, combinationally, in the same cycle.
  - On that handshake: latch the request fields, set grant, go to REQ.
  - For the IFU: mem_wen = 0 and mem_wmask = 0 are latched.
  - With no requests: stay in IDLE.
- REQ:
  - mem_req_valid = 1, driven from latched fields only; stable until accepted.
  - mem_req_ready = 1 -> RESP in the next cycle.
- RESP:
  - mem_resp_ready = granted master's resp_ready.
  - Granted master's resp_valid = mem_resp_valid; its rdata = mem_rdata (combinational passthrough).
  - On mem_resp_valid & resp_ready: grant = NONE, go to IDLE.
- Non-granted master: resp_valid = 0 and req_ready = 0 at all times.
- rdata outputs are 0 when the port is not granted or not in RESP.
- mem_resp_valid is ignored in IDLE/REQ; mem_resp_ready = 0 there.
- Minimum latency: accept in cycle 0, mem_req_valid in cycle 1, response earliest in cycle 2.
  - One mandatory IDLE bubble between back-to-back transactions.
- Default arbitration (fixed priority): LSU wins when both request. An IFU request waits in IDLE; the IFU holds valid per protocol.
- Writes: the response handshake is still required (the memory returns an ack with don't-care rdata).
- Reset mid-transaction (REQ or RESP):
  - Return to IDLE next cycle and drop the transaction; no response is delivered.
  - mem_req_valid and mem_resp_ready go to 0.
- Masters dropping req_valid before acceptance is legal; nothing is latched.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN
- Defined: round-robin arbitration.
  - When both request in IDLE, grant the master that is not last_grant.
  - last_grant is updated on every accepted request.
  - Single requester: always granted.
- Undefined:
  - Fixed LSU priority.
  - last_grant register absent; reset state unaffected otherwise.

Test Plan:
- IFU only:
  - Stimulus: ifu_addr=0x80000000; memory returns rdata=0x00000413 one cycle after mem_req.
  - Required: ifu_req_ready in cycle 0; mem_req_valid in cycle 1 with addr 0x80000000, mem_wen=0, mem_wmask=0; ifu_resp_valid with 0x00000413 in cycle 2.
- Simultaneous IFU and LSU load (0x80001000), fixed priority:
  - Required: LSU served first, then the IFU after the bubble.
  - With MEM_ARBITER_RR_EN after reset: LSU first (last_grant=IFU); a second simultaneous pair then serves the IFU first.
- LSU store wdata=0xDEADBEEF, wmask=0x0F, mem_req_ready held 0 for 3 cycles:
  - Required: mem fields stable throughout; state stays REQ; lsu_resp_valid only after the ack.
- Response backpressure: lsu_resp_ready=0 for 2 cycles while mem_resp_valid=1:
  - Required: mem_resp_ready=0, state stays RESP; completes when lsu_resp_ready=1; ifu_resp_valid stays 0 throughout.
- rst asserted in RESP:
  - Required: next cycle IDLE; all outputs 0; a fresh IFU request is then served normally.
